lgdst_ts_txser: RTL and testbench
=================================

Name: lgdst_ts_txser

Overview:
- Transmit-direction glue for the LGDST link: a serial-TS transmitter.
- An MCU SPI master writes transport-stream bytes into this block through an SPI slave port.
- The bytes are buffered in a small FIFO.
- The block re-emits them as a serial TS stream (ts_clk/ts_d0/ts_valid/ts_sync) toward the modulator.
- Packets are aligned on the sync byte.

Parameters:
- TS_CLK_DIV, 5: ts_clk half-period in clk cycles; 50 MHz clk gives 5 MHz ts_clk.
- FIFO_DEPTH, 16: byte FIFO depth; power of 2, at least 4.
- PKT_BYTES, 188: bytes per TS packet, including the sync byte.
- SYNC_BYTE, 8'h47: packet start marker.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- spi_spck  in  1  SPI slave clock from MCU, mode 0, asynchronous to clk
- spi_npcs0  in  1  SPI slave chip select, active low
- spi_mosi  in  1  SPI slave data, MSB first
- ts_clk  out  1  serial TS clock
- ts_d0  out  1  serial TS data, MSB first
- ts_valid  out  1  high while ts_d0 carries packet bits
- ts_sync  out  1  high during the first bit of each packet
- fifo_ovf  out  1  sticky: a byte was dropped because the FIFO was full
- pkt_cnt  out  16  packets fully transmitted; wraps 16'hFFFF to 0

Behaviour:
- Reset (rst=1, asynchronous):
  - ts_clk=0, ts_d0=0, ts_valid=0, ts_sync=0, fifo_ovf=0, pkt_cnt=0.
  - FIFO emptied, SPI bit counter cleared, serializer in HUNT.
  - Reset mid-packet aborts the packet immediately; nothing is resumed.
- SPI input:
  - spck, npcs0 and mosi each pass through a 2-flop synchronizer to clk.
  - A rising edge is detected from the synchronized spck.
  - On each rising edge with npcs0 low, mosi shifts into an 8-bit shift register and a 3-bit counter increments.
  - On the 8th bit the byte is written to the FIFO in the following clk cycle.
  - npcs0 high clears the counter; a partial byte is discarded.
  - Supported spck is at most clk/5.
- FIFO:
  - Synchronous, single clk.
  - Write while full: byte dropped, fifo_ovf set until reset.
  - Simultaneous read and write while full is allowed; the write is accepted.
- ts_clk:
  - Free-running toggle every TS_CLK_DIV clk cycles.
  - ts_d0, ts_valid and ts_sync change only in the clk cycle that drives ts_clk falling, so they are stable at the rising edge.
- Serializer FSM, all decisions taken at ts_clk falling-edge ticks:
  - HUNT: if the FIFO is non-empty, pop one byte. If it equals SYNC_BYTE, load it, set byte_idx=0, go to SHIFT. Otherwise discard it and stay in HUNT. Outputs valid=0, sync=0.
  - SHIFT:
    - Drive bits 7..0 over 8 ticks with valid=1.
    - sync=1 only on bit 7 when byte_idx=0.
    - After bit 0:
      - If byte_idx=PKT_BYTES-1: pkt_cnt+1, go to HUNT.
      - Else if the FIFO is non-empty: pop the next byte, byte_idx+1, continue without a gap.
      - Else: go to STALL.
  - STALL: valid=0, sync=0, ts_d0 holds its last value. Leave at the first tick with the FIFO non-empty: pop, byte_idx+1, return to SHIFT. A packet may therefore contain valid gaps.
- Payload bytes equal to SYNC_BYTE at byte_idx>0 are ordinary data.
- Latency: the first bit of a sync byte appears on ts_d0 at most 2*TS_CLK_DIV+4 clk cycles after the FIFO write.

Optional Feature:
- Macro: TS_SYNC_WIDE_EN.
- Defined: ts_sync stays high for all 8 bits of byte 0 (byte-wide sync, DVB parallel-style).
- Undefined: ts_sync is high for bit 7 of byte 0 only.

Test Plan:
- Reset then idle, no SPI traffic, 1000 clk cycles:
  - ts_clk toggles with a 200 ns period.
  - ts_valid, ts_sync, fifo_ovf, pkt_cnt stay 0.
- PKT_BYTES=8; SPI writes 47,11,22,33,44,55,66,77:
  - ts_d0 serializes 0x47 first, MSB first.
  - ts_sync high for exactly 1 ts_clk (8 with TS_SYNC_WIDE_EN).
  - ts_valid high for 64 contiguous ts_clk.
  - pkt_cnt=1.
- PKT_BYTES=8; write 00,AA, then 47,22,44,66,88,AA,CC,EE:
  - 00 and AA are discarded in HUNT.
  - One packet is sent starting with 47; pkt_cnt=1.
- PKT_BYTES=8; write 47,22,44, then a 20 µs SPI pause, then the remaining 5 bytes:
  - ts_valid drops after 24 bits and resumes with 0x66 (the 4th byte).
  - No ts_sync on resume; pkt_cnt=1 at the end.
- FIFO_DEPTH=4; burst 12 bytes at max SPI rate while the serializer is stalled (rst released after the burst is not used):
  - fifo_ovf=1 and stays 1.
  - Only the first accepted bytes are serialized.
- Pulse spi_npcs0 high after 5 bits:
  - The partial byte is never written.
  - The next full byte is received intact.
- Assert rst mid-packet:
  - All outputs are 0 within the same cycle.
  - After release, HUNT requires a fresh 47.

Source files
------------

// File: rtl/lgdst_ts_txser_if.sv
// Bus bundle for lgdst_ts_txser: SPI slave inputs from the MCU and the
// serial-TS outputs toward the modulator, plus status.
// slave  : the transmitter block itself
// master : whoever drives the SPI side and observes the TS side
interface lgdst_ts_txser_if;
    logic        spi_spck;
    logic        spi_npcs0;
    logic        spi_mosi;
    logic        ts_clk;
    logic        ts_d0;
    logic        ts_valid;
    logic        ts_sync;
    logic        fifo_ovf;
    logic [15:0] pkt_cnt;

    modport slave (
        input  spi_spck, spi_npcs0, spi_mosi,
        output ts_clk, ts_d0, ts_valid, ts_sync, fifo_ovf, pkt_cnt
    );

    modport master (
        output spi_spck, spi_npcs0, spi_mosi,
        input  ts_clk, ts_d0, ts_valid, ts_sync, fifo_ovf, pkt_cnt
    );
endinterface

// File: rtl/lgdst_ts_txser.sv
// lgdst_ts_txser: SPI-slave byte receiver -> small byte FIFO -> serial TS
// transmitter with sync-byte packet alignment.
// Optional macro TS_SYNC_WIDE_EN: when defined, ts_sync covers all 8 bits of
// the sync byte; otherwise only its first (MSB) bit.
module lgdst_ts_txser #(
    parameter int         TS_CLK_DIV = 5,
    parameter int         FIFO_DEPTH = 16,
    parameter int         PKT_BYTES  = 188,
    parameter logic [7:0] SYNC_BYTE  = 8'h47
) (
    input  logic            clk,
    input  logic            rst,
    lgdst_ts_txser_if.slave bus_io
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = (TS_CLK_DIV > 1) ? $clog2(TS_CLK_DIV) : 1;
    localparam int IW = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TS_CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(PKT_BYTES - 1);

    // ---------------- SPI slave ----------------
    logic [2:0] spck_q;       // [1:0] synchronizer, [2] previous for edge detect
    logic [1:0] npcs_q;
    logic [1:0] mosi_q;
    logic [6:0] shift_q;
    logic [2:0] bit_cnt_q;
    logic       wr_pend_q;
    logic [7:0] wr_byte_q;
    logic       spck_rise;

    assign spck_rise = spck_q[1] & ~spck_q[2];

    // Synchronize SPI pins, shift MOSI on spck rising edges, hand off full bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spck_q    <= '0;
            npcs_q    <= 2'b11;
            mosi_q    <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            wr_pend_q <= 1'b0;
            wr_byte_q <= '0;
        end else begin
            spck_q    <= {spck_q[1:0], bus_io.spi_spck};
            npcs_q    <= {npcs_q[0], bus_io.spi_npcs0};
            mosi_q    <= {mosi_q[0], bus_io.spi_mosi};
            wr_pend_q <= 1'b0;
            if (npcs_q[1]) begin
                // Deselect discards any partial byte.
                bit_cnt_q <= '0;
            end else if (spck_rise) begin
                shift_q   <= {shift_q[5:0], mosi_q[1]};
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    wr_pend_q <= 1'b1;
                    wr_byte_q <= {shift_q, mosi_q[1]};
                end
            end
        end
    end

    // ---------------- Byte FIFO ----------------
    // Head is read combinationally so the serializer can decide and pop in the
    // same tick; the array is small enough for distributed memory.
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        fifo_empty, fifo_full, fifo_push, fifo_pop;
    logic [7:0]  fifo_head;
    logic        ovf_q;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A pop in the same cycle frees the slot, so a write while full is accepted.
    assign fifo_push  = wr_pend_q && (!fifo_full || fifo_pop);
    assign fifo_head  = mem_q[rd_ptr_q[AW-1:0]];

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_byte_q;
        end
    end

    // Pointer update and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (fifo_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr_pend_q && !fifo_push) ovf_q <= 1'b1;
        end
    end

    // ---------------- ts_clk generator ----------------
    logic [DW-1:0] div_q;
    logic          ts_clk_q;
    logic          fall_tick;

    // High in the clk cycle whose edge drives ts_clk low.
    assign fall_tick = (div_q == DIV_LAST) && ts_clk_q;

    // Free-running divider toggling ts_clk every TS_CLK_DIV cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q    <= '0;
            ts_clk_q <= 1'b0;
        end else if (div_q == DIV_LAST) begin
            div_q    <= '0;
            ts_clk_q <= ~ts_clk_q;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // ---------------- Serializer FSM ----------------
    typedef enum logic [1:0] {ST_HUNT, ST_SHIFT, ST_STALL} state_t;

    state_t        state_q, state_d;
    logic [7:0]    byte_q, byte_d;
    logic [2:0]    bpos_q, bpos_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          d0_q, d0_d, valid_q, valid_d, sync_q, sync_d;
    logic [15:0]   pkt_q, pkt_d;
    logic          load_next;

    // Serializer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_HUNT;
            byte_q  <= '0;
            bpos_q  <= '0;
            idx_q   <= '0;
            d0_q    <= 1'b0;
            valid_q <= 1'b0;
            sync_q  <= 1'b0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            bpos_q  <= bpos_d;
            idx_q   <= idx_d;
            d0_q    <= d0_d;
            valid_q <= valid_d;
            sync_q  <= sync_d;
            pkt_q   <= pkt_d;
        end
    end

    // Next-state and output decisions, evaluated only on ts_clk falling ticks.
    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        bpos_d    = bpos_q;
        idx_d     = idx_q;
        d0_d      = d0_q;
        valid_d   = valid_q;
        sync_d    = sync_q;
        pkt_d     = pkt_q;
        fifo_pop  = 1'b0;
        load_next = 1'b0;
        if (fall_tick) begin
            case (state_q)
                ST_HUNT: begin
                    valid_d = 1'b0;
                    sync_d  = 1'b0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        if (fifo_head == SYNC_BYTE) begin
                            // First bit of the packet goes out on this very tick.
                            byte_d  = fifo_head;
                            idx_d   = '0;
                            bpos_d  = 3'd7;
                            d0_d    = fifo_head[7];
                            valid_d = 1'b1;
                            sync_d  = 1'b1;
                            state_d = ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (bpos_q != 3'd0) begin
                        bpos_d  = bpos_q - 3'd1;
                        d0_d    = byte_q[bpos_d];
                        valid_d = 1'b1;
`ifdef TS_SYNC_WIDE_EN
                        sync_d  = (idx_q == '0);
`else
                        sync_d  = 1'b0;
`endif
                    end else if (idx_q == IDX_LAST) begin
                        pkt_d   = pkt_q + 16'd1;
                        valid_d = 1'b0;
                        sync_d  = 1'b0;
                        state_d = ST_HUNT;
                    end else if (!fifo_empty) begin
                        load_next = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        sync_d  = 1'b0;
                        state_d = ST_STALL;
                    end
                end
                ST_STALL: begin
                    valid_d = 1'b0;
                    sync_d  = 1'b0;
                    if (!fifo_empty) load_next = 1'b1;
                end
                default: state_d = ST_HUNT;
            endcase
            if (load_next) begin
                // Continue the packet with the next FIFO byte, MSB first.
                fifo_pop = 1'b1;
                byte_d   = fifo_head;
                idx_d    = idx_q + 1'b1;
                bpos_d   = 3'd7;
                d0_d     = fifo_head[7];
                valid_d  = 1'b1;
                sync_d   = 1'b0;
                state_d  = ST_SHIFT;
            end
        end
    end

    assign bus_io.ts_clk   = ts_clk_q;
    assign bus_io.ts_d0    = d0_q;
    assign bus_io.ts_valid = valid_q;
    assign bus_io.ts_sync  = sync_q;
    assign bus_io.fifo_ovf = ovf_q;
    assign bus_io.pkt_cnt  = pkt_q;
endmodule

// File: tb/tb_lgdst_ts_txser.sv
`timescale 1ns/1ps
// Bench for lgdst_ts_txser with PKT_BYTES=8 and FIFO_DEPTH=4: random TS bytes
// over SPI, the serial TS stream is decoded and compared with a byte-level
// packetizer model.
module tb_lgdst_ts_txser;
    localparam int         TS_CLK_DIV = 5;
    localparam int         FIFO_DEPTH = 4;
    localparam int         PKT_BYTES  = 8;
    localparam logic [7:0] SYNC       = 8'h47;
    localparam int         HALF       = 3;   // spck half-period in clk cycles
`ifdef TS_SYNC_WIDE_EN
    localparam int         SYNC_BITS  = 8;
`else
    localparam int         SYNC_BITS  = 1;
`endif

    logic clk, rst;
    lgdst_ts_txser_if bus();

    lgdst_ts_txser #(
        .TS_CLK_DIV(TS_CLK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH),
        .PKT_BYTES (PKT_BYTES),
        .SYNC_BYTE (SYNC)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- TS monitor ----------------
    logic bits_q[$];
    int   sync_idx_q[$];
    int   runs_q[$];
    int   run_len = 0;
    logic ts_clk_prev = 1'b0;
    time  last_rise_t = 0;
    time  period_t = 0;
    int   rise_cnt = 0;
    int   valid_hi_cnt = 0;
    int   sync_hi_cnt = 0;

    always @(negedge clk) begin
        if (bus.ts_valid === 1'b1) valid_hi_cnt++;
        if (bus.ts_sync === 1'b1) sync_hi_cnt++;
        if (bus.ts_clk === 1'b1 && ts_clk_prev === 1'b0) begin
            rise_cnt++;
            period_t    = $time - last_rise_t;
            last_rise_t = $time;
            if (bus.ts_valid === 1'b1) begin
                if (bus.ts_sync === 1'b1) sync_idx_q.push_back(bits_q.size());
                bits_q.push_back(bus.ts_d0);
                run_len++;
            end else if (run_len > 0) begin
                runs_q.push_back(run_len);
                run_len = 0;
            end
        end
        ts_clk_prev = bus.ts_clk;
    end

    logic [7:0] sent_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int run_at(input int i);
        return (i < runs_q.size()) ? runs_q[i] : -1;
    endfunction

    function automatic logic [7:0] rnd_non_sync();
        logic [7:0] v;
        v = 8'($urandom_range(0, 255));
        if (v == SYNC) v = 8'h48;
        return v;
    endfunction

    // ---------------- SPI driver (mode 0, MSB first) ----------------
    task automatic spi_sel(input logic level);
        bus.spi_npcs0 = level;
        repeat (4) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            bus.spi_mosi = b[i];
            repeat (HALF) @(negedge clk);
            bus.spi_spck = 1'b1;
            repeat (HALF) @(negedge clk);
            bus.spi_spck = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] b);
        spi_bits(b, 8);
        sent_q.push_back(b);
    endtask

    // ---------------- Reference model ----------------
    // Packetizer: skip bytes until a sync byte, then emit PKT_BYTES bytes
    // verbatim, then hunt again.
    task automatic model_stream();
        int  idx;
        bit  hunting;
        exp_q.delete();
        hunting = 1'b1;
        idx     = 0;
        foreach (sent_q[k]) begin
            if (hunting) begin
                if (sent_q[k] == SYNC) begin
                    exp_q.push_back(sent_q[k]);
                    hunting = 1'b0;
                    idx     = 1;
                end
            end else begin
                exp_q.push_back(sent_q[k]);
                idx++;
                if (idx == PKT_BYTES) hunting = 1'b1;
            end
        end
    endtask

    task automatic decode(input int base);
        int nb;
        logic [7:0] b;
        got_q.delete();
        nb = (bits_q.size() - base) / 8;
        for (int k = 0; k < nb; k++) begin
            b = '0;
            for (int j = 0; j < 8; j++) b = {b[6:0], bits_q[base + 8*k + j]};
            got_q.push_back(b);
        end
    endtask

    task automatic wait_pkt(input int exp_cnt, input string tag);
        int n;
        n = 0;
        while (int'(bus.pkt_cnt) != exp_cnt && n < 4000) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        chk(tag, 32'(bus.pkt_cnt), exp_cnt);
    endtask

    task automatic check_stream(input string tag, input int base);
        int n;
        model_stream();
        decode(base);
        chk({tag, "_nbytes"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    task automatic check_sync(input string tag, input int base);
        int cnt, first, last;
        cnt = 0; first = -1; last = -1;
        foreach (sync_idx_q[k]) begin
            if (sync_idx_q[k] >= base) begin
                if (cnt == 0) first = sync_idx_q[k] - base;
                last = sync_idx_q[k] - base;
                cnt++;
            end
        end
        chk({tag, "_sync_count"}, cnt, SYNC_BITS);
        chk({tag, "_sync_first"}, first, 0);
        chk({tag, "_sync_last"}, last, SYNC_BITS - 1);
    endtask

    // ---------------- Directed sequence ----------------
    initial begin
        int base, rb, n, lat, r0, v0, s0, j;
        logic ok;

        rst = 1'b1;
        bus.spi_spck  = 1'b0;
        bus.spi_npcs0 = 1'b1;
        bus.spi_mosi  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({bus.ts_clk, bus.ts_d0, bus.ts_valid, bus.ts_sync,
                                   bus.fifo_ovf, bus.pkt_cnt}), 0);
        rst = 1'b0;

        // Idle: free-running ts_clk, nothing else moves.
        r0 = rise_cnt; v0 = valid_hi_cnt; s0 = sync_hi_cnt;
        repeat (1000) @(negedge clk);
        chk("idle_tsclk_period_ns", 32'(period_t), 200);
        chk("idle_tsclk_toggles", 32'((rise_cnt - r0) >= 99 && (rise_cnt - r0) <= 101), 1);
        chk("idle_valid_hi", valid_hi_cnt - v0, 0);
        chk("idle_sync_hi", sync_hi_cnt - s0, 0);
        chk("idle_ovf", 32'(bus.fifo_ovf), 0);
        chk("idle_pkt_cnt", 32'(bus.pkt_cnt), 0);

        // Packet 1: sync + random payload, latency and contiguity.
        sent_q.delete(); base = bits_q.size(); rb = runs_q.size();
        spi_sel(1'b0);
        spi_byte(SYNC);
        n = 0;
        while (bus.ts_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        lat = HALF + n;
        chk("pkt1_latency_in_bound", 32'(lat >= 5 && lat <= 2*TS_CLK_DIV + 8), 1);
        for (int i = 1; i < PKT_BYTES; i++) spi_byte(8'($urandom_range(0, 255)));
        spi_sel(1'b1);
        wait_pkt(1, "pkt1_cnt");
        check_stream("pkt1", base);
        check_sync("pkt1", base);
        chk("pkt1_nruns", runs_q.size() - rb, 1);
        chk("pkt1_run_len", run_at(rb), 64);

        // Packet 2: junk bytes ahead of the sync byte are hunted away.
        sent_q.delete(); base = bits_q.size(); rb = runs_q.size();
        spi_sel(1'b0);
        spi_byte(rnd_non_sync());
        spi_byte(rnd_non_sync());
        spi_byte(SYNC);
        for (int i = 1; i < PKT_BYTES; i++) spi_byte(8'($urandom_range(0, 255)));
        spi_sel(1'b1);
        wait_pkt(2, "pkt2_cnt");
        check_stream("pkt2", base);
        chk("pkt2_run_len", run_at(rb), 64);

        // Packet 3: SPI pause after 3 bytes forces a stall gap.
        sent_q.delete(); base = bits_q.size(); rb = runs_q.size();
        spi_sel(1'b0);
        spi_byte(SYNC);
        for (int i = 1; i < 3; i++) spi_byte(8'($urandom_range(0, 255)));
        spi_sel(1'b1);
        repeat (1000) @(negedge clk);
        spi_sel(1'b0);
        for (int i = 3; i < PKT_BYTES; i++) spi_byte(8'($urandom_range(0, 255)));
        spi_sel(1'b1);
        wait_pkt(3, "pkt3_cnt");
        check_stream("pkt3", base);
        check_sync("pkt3", base);
        chk("pkt3_nruns", runs_q.size() - rb, 2);
        chk("pkt3_run0_len", run_at(rb), 24);
        chk("pkt3_run1_len", run_at(rb + 1), 40);

        // Packet 4: a 5-bit partial byte cut by deselect is never written.
        sent_q.delete(); base = bits_q.size();
        spi_sel(1'b0);
        spi_byte(SYNC);
        spi_byte(8'($urandom_range(0, 255)));
        spi_bits(8'($urandom_range(0, 255)), 5);
        spi_sel(1'b1);
        repeat (10) @(negedge clk);
        spi_sel(1'b0);
        for (int i = 2; i < PKT_BYTES; i++) spi_byte(8'($urandom_range(0, 255)));
        spi_sel(1'b1);
        wait_pkt(4, "pkt4_cnt");
        check_stream("pkt4", base);
        chk("pre_burst_ovf", 32'(bus.fifo_ovf), 0);

        // Packet 5: back-to-back burst outruns the serializer and overflows.
        sent_q.delete(); base = bits_q.size();
        spi_sel(1'b0);
        spi_byte(SYNC);
        for (int i = 1; i < 16; i++) spi_byte(rnd_non_sync());
        spi_sel(1'b1);
        wait_pkt(5, "burst_pkt_cnt");
        chk("burst_ovf_set", 32'(bus.fifo_ovf), 1);
        decode(base);
        chk("burst_nbytes", got_q.size(), PKT_BYTES);
        for (int i = 0; i < 5; i++)
            chk($sformatf("burst_head_byte%0d", i),
                (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF, 32'(sent_q[i]));
        ok = 1'b1; j = 0;
        foreach (got_q[i]) begin
            while (j < sent_q.size() && sent_q[j] != got_q[i]) j++;
            if (j >= sent_q.size()) ok = 1'b0;
            else j++;
        end
        chk("burst_in_order_subset", 32'(ok), 1);
        repeat (600) @(negedge clk);
        chk("burst_ovf_sticky", 32'(bus.fifo_ovf), 1);
        chk("burst_no_extra_pkt", 32'(bus.pkt_cnt), 5);

        // Reset in the middle of a packet.
        sent_q.delete(); base = bits_q.size();
        spi_sel(1'b0);
        spi_byte(SYNC);
        for (int i = 1; i < 4; i++) spi_byte(rnd_non_sync());
        spi_sel(1'b1);
        n = 0;
        while (bits_q.size() < base + 12 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_midpkt_reached", 32'(bits_q.size() >= base + 12), 1);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_async_outputs", 32'({bus.ts_clk, bus.ts_d0, bus.ts_valid, bus.ts_sync,
                                       bus.fifo_ovf, bus.pkt_cnt}), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Rest of the aborted packet must not be framed without a fresh sync.
        sent_q.delete(); base = bits_q.size();
        spi_sel(1'b0);
        for (int i = 0; i < 4; i++) spi_byte(rnd_non_sync());
        spi_sel(1'b1);
        repeat (600) @(negedge clk);
        chk("post_rst_no_bits", bits_q.size() - base, 0);
        chk("post_rst_pkt_cnt", 32'(bus.pkt_cnt), 0);

        // Fresh packet after reset.
        sent_q.delete(); base = bits_q.size();
        spi_sel(1'b0);
        spi_byte(SYNC);
        for (int i = 1; i < PKT_BYTES; i++) spi_byte(8'($urandom_range(0, 255)));
        spi_sel(1'b1);
        wait_pkt(1, "fresh_pkt_cnt");
        check_stream("fresh", base);
        check_sync("fresh", base);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
